// File: rtl/div32_iter_if.sv
// Handshake and operand bundle for the iterative 32-bit divider.
// ERR exists only when DIV32_DBZ_ERR_EN is defined.
interface div32_iter_if #(
  parameter int W = 32
);
  logic         START;
  logic         SnU;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] HI;
  logic [W-1:0] LO;
  logic         BUSY;
  logic         DONE;
`ifdef DIV32_DBZ_ERR_EN
  logic         ERR;
`endif

`ifdef DIV32_DBZ_ERR_EN
  modport master (
    output START, SnU, A, B,
    input  HI, LO, BUSY, DONE, ERR
  );
  modport slave (
    input  START, SnU, A, B,
    output HI, LO, BUSY, DONE, ERR
  );
`else
  modport master (
    output START, SnU, A, B,
    input  HI, LO, BUSY, DONE
  );
  modport slave (
    input  START, SnU, A, B,
    output HI, LO, BUSY, DONE
  );
`endif
endinterface

// File: rtl/div32_iter.sv
// Restoring divider, one quotient bit per clock: LO=quotient, HI=remainder.
// Optional DIV32_DBZ_ERR_EN adds a sticky-until-next-op divide-by-zero flag.
module div32_iter #(
  parameter int WIDTH = 32,
  parameter int ITERS = 32
) (
  input logic         CLK,
  input logic         RST,
  div32_iter_if.slave bus
);
  localparam int CW = $clog2(ITERS);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ITER,
    FIX
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_a;
  logic             r_sa;
  logic             r_sb;
  logic             r_dbz;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_amag;
  logic [WIDTH-1:0] w_bmag;
  logic [WIDTH:0]   w_sh;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_qfix;
  logic [WIDTH-1:0] w_rfix;

  assign w_amag = (bus.SnU & bus.A[WIDTH-1]) ? -bus.A : bus.A;
  assign w_bmag = (bus.SnU & bus.B[WIDTH-1]) ? -bus.B : bus.B;

  // Partial remainder stays below the divisor, so 33 bits hold the trial sign
  assign w_sh   = {r_rem, r_quo[WIDTH-1]};
  assign w_diff = w_sh - {1'b0, r_div};
  assign w_qfix = (r_sa ^ r_sb) ? -r_quo : r_quo;
  assign w_rfix = r_sa ? -r_rem : r_rem;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_a     <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_dbz   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE, LOAD: begin
          if (bus.START) begin
            r_a     <= bus.A;
            r_quo   <= w_amag;
            r_div   <= w_bmag;
            r_rem   <= '0;
            r_sa    <= bus.A[WIDTH-1] & bus.SnU;
            r_sb    <= bus.B[WIDTH-1] & bus.SnU;
            r_dbz   <= (bus.B == '0);
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ITER;
          end
        end
        ITER: begin
          if (!w_diff[WIDTH]) begin
            r_rem <= w_diff[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
          end else begin
            r_rem <= w_sh[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(ITERS - 1))
            r_state <= FIX;
        end
        FIX: begin
          r_lo    <= r_dbz ? '1  : w_qfix;
          r_hi    <= r_dbz ? r_a : w_rfix;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef DIV32_DBZ_ERR_EN
  logic r_err;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      r_err <= 1'b0;
    else if (r_state == FIX)
      r_err <= r_dbz;
  end

  assign bus.ERR = r_err;
`endif

  assign bus.HI   = r_hi;
  assign bus.LO   = r_lo;
  assign bus.BUSY = r_busy;
  assign bus.DONE = r_done;
endmodule
